// File: rtl/xui_arbiter.sv
// xui_arbiter: two-requester round-robin arbiter in front of the MIG user
// interface. Sequences the app_* command and write-data channels and routes
// in-order read returns back to the issuing requester via an owner FIFO.
module xui_arbiter #(
    parameter int ADDR_SIZE = 31,
    parameter int DATA_SIZE = 64,
    parameter int RDQ_DEPTH = 8
) (
    input  logic                   ui_clk,
    input  logic                   ui_clk_sync_rst,
    // requester 0
    input  logic                   m0_en,
    input  logic                   m0_write,
    input  logic [ADDR_SIZE-1:0]   m0_addr,
    input  logic [DATA_SIZE-1:0]   m0_wdata,
    input  logic [DATA_SIZE/8-1:0] m0_wmask,
    output logic                   m0_rdy,
    output logic [DATA_SIZE-1:0]   m0_rd_data,
    output logic                   m0_rd_valid,
    // requester 1
    input  logic                   m1_en,
    input  logic                   m1_write,
    input  logic [ADDR_SIZE-1:0]   m1_addr,
    input  logic [DATA_SIZE-1:0]   m1_wdata,
    input  logic [DATA_SIZE/8-1:0] m1_wmask,
    output logic                   m1_rdy,
    output logic [DATA_SIZE-1:0]   m1_rd_data,
    output logic                   m1_rd_valid,
    // MIG user interface
    output logic [ADDR_SIZE-1:0]   app_addr,
    output logic [2:0]             app_cmd,
    output logic                   app_en,
    input  logic                   app_rdy,
    output logic [DATA_SIZE-1:0]   app_wdf_data,
    output logic [DATA_SIZE/8-1:0] app_wdf_mask,
    output logic                   app_wdf_wren,
    output logic                   app_wdf_end,
    input  logic                   app_wdf_rdy,
    input  logic [DATA_SIZE-1:0]   app_rd_data,
    input  logic                   app_rd_data_valid,
    input  logic                   init_calib_complete,
    output logic                   rd_orphan_err
);

    localparam int MASK_SIZE = DATA_SIZE / 8;
    localparam int PTR_W     = $clog2(RDQ_DEPTH);
    localparam logic [PTR_W:0] FIFO_FULL_CNT = (PTR_W + 1)'(RDQ_DEPTH);
    localparam logic [2:0] CMD_WRITE = 3'b000;
    localparam logic [2:0] CMD_READ  = 3'b001;

    typedef enum logic {
        ST_IDLE,
        ST_ISSUE
    } state_t;

    state_t                 r_state;
    state_t                 w_state_next;
    logic                   r_last_grant;
    logic                   r_cmd_done;
    logic                   r_data_done;
    logic [ADDR_SIZE-1:0]   r_addr;
    logic [2:0]             r_cmd;
    logic [DATA_SIZE-1:0]   r_wdata;
    logic [MASK_SIZE-1:0]   r_wmask;
    logic                   r_owner;

    // per-requester views so both sides are handled uniformly
    logic [1:0]             w_en;
    logic [1:0]             w_write;
    logic [1:0]             w_elig;
    logic [1:0]             w_grant;
    logic [ADDR_SIZE-1:0]   w_addr  [2];
    logic [DATA_SIZE-1:0]   w_wdata [2];
    logic [MASK_SIZE-1:0]   w_wmask [2];
    logic                   w_sel;

    logic                   w_app_en;
    logic                   w_app_wren;
    logic                   w_cmd_fin;
    logic                   w_data_fin;

    // owner FIFO: one bit per outstanding read naming the requester
    logic                   r_owner_mem [RDQ_DEPTH];
    logic [PTR_W-1:0]       r_wr_ptr;
    logic [PTR_W-1:0]       r_rd_ptr;
    logic [PTR_W:0]         r_count;
    logic                   w_fifo_full;
    logic                   w_fifo_empty;
    logic                   w_push;
    logic                   w_pop;
    logic                   w_head;

    logic [DATA_SIZE-1:0]   r_rd_data;
    logic [1:0]             r_rd_valid;
    logic                   r_orphan;

    assign w_en       = {m1_en, m0_en};
    assign w_write    = {m1_write, m0_write};
    assign w_addr[0]  = m0_addr;
    assign w_addr[1]  = m1_addr;
    assign w_wdata[0] = m0_wdata;
    assign w_wdata[1] = m1_wdata;
    assign w_wmask[0] = m0_wmask;
    assign w_wmask[1] = m1_wmask;

    assign w_fifo_full  = (r_count == FIFO_FULL_CNT);
    assign w_fifo_empty = (r_count == '0);
    assign w_head       = r_owner_mem[r_rd_ptr];

    // a read is only eligible while there is room to track its owner
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_elig
            assign w_elig[gi] = w_en[gi] & init_calib_complete & ~ui_clk_sync_rst &
                                (w_write[gi] | ~w_fifo_full);
        end
    endgenerate

    // each channel drops independently once the MIG has taken it
    assign w_app_en   = (r_state == ST_ISSUE) & ~r_cmd_done;
    assign w_app_wren = (r_state == ST_ISSUE) & ~r_data_done;
    assign w_cmd_fin  = r_cmd_done  | (w_app_en & app_rdy);
    assign w_data_fin = r_data_done | (w_app_wren & app_wdf_rdy);

    assign w_push = w_app_en & app_rdy & (r_cmd == CMD_READ);
    assign w_pop  = app_rd_data_valid & ~w_fifo_empty;

    // grant selection and next state; tie goes to the requester not served last
    always_comb begin
        w_state_next = r_state;
        w_grant      = 2'b00;
        case (r_state)
            ST_IDLE: begin
                if (|w_elig) begin
                    if (w_elig[1] && (!w_elig[0] || (r_last_grant == 1'b0))) begin
                        w_grant = 2'b10;
                    end else begin
                        w_grant = 2'b01;
                    end
                    w_state_next = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (w_cmd_fin && w_data_fin) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    assign w_sel = w_grant[1];

    // state register, handshake flags and the latched command
    always_ff @(posedge ui_clk) begin
        if (ui_clk_sync_rst) begin
            r_state      <= ST_IDLE;
            r_last_grant <= 1'b1;
            r_cmd_done   <= 1'b0;
            r_data_done  <= 1'b0;
            r_addr       <= '0;
            r_cmd        <= CMD_READ;
            r_wdata      <= '0;
            r_wmask      <= '0;
            r_owner      <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (|w_grant) begin
                r_last_grant <= w_sel;
                r_owner      <= w_sel;
                r_addr       <= w_addr[w_sel];
                r_cmd        <= w_write[w_sel] ? CMD_WRITE : CMD_READ;
                r_wdata      <= w_wdata[w_sel];
                r_wmask      <= w_wmask[w_sel];
                r_cmd_done   <= 1'b0;
                // reads have no data beat, so that channel starts out complete
                r_data_done  <= ~w_write[w_sel];
            end else if (r_state == ST_ISSUE) begin
                if (w_cmd_fin && w_data_fin) begin
                    r_cmd_done  <= 1'b0;
                    r_data_done <= 1'b0;
                end else begin
                    r_cmd_done  <= w_cmd_fin;
                    r_data_done <= w_data_fin;
                end
            end
        end
    end

    // owner FIFO storage, written when a read command is accepted
    always_ff @(posedge ui_clk) begin
        if (w_push) begin
            r_owner_mem[r_wr_ptr] <= r_owner;
        end
    end

    // owner FIFO pointers and occupancy
    always_ff @(posedge ui_clk) begin
        if (ui_clk_sync_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // read return steering plus sticky error for data with no owner
    always_ff @(posedge ui_clk) begin
        if (ui_clk_sync_rst) begin
            r_rd_data  <= '0;
            r_rd_valid <= 2'b00;
            r_orphan   <= 1'b0;
        end else begin
            r_rd_valid <= 2'b00;
            if (w_pop) begin
                r_rd_data  <= app_rd_data;
                r_rd_valid <= w_head ? 2'b10 : 2'b01;
            end
            if (app_rd_data_valid && w_fifo_empty) begin
                r_orphan <= 1'b1;
            end
        end
    end

    assign m0_rdy        = w_grant[0];
    assign m1_rdy        = w_grant[1];
    assign m0_rd_data    = r_rd_data;
    assign m1_rd_data    = r_rd_data;
    assign m0_rd_valid   = r_rd_valid[0];
    assign m1_rd_valid   = r_rd_valid[1];
    assign app_addr      = r_addr;
    assign app_cmd       = r_cmd;
    assign app_en        = w_app_en;
    assign app_wdf_data  = r_wdata;
    assign app_wdf_mask  = r_wmask;
    assign app_wdf_wren  = w_app_wren;
    assign app_wdf_end   = w_app_wren;
    assign rd_orphan_err = r_orphan;

endmodule

// File: tb/tb_xui_arbiter.sv
// Testbench for xui_arbiter: directed stimulus with expected grants, commands,
// write beats and read returns queued up front and checked by a monitor.
module tb_xui_arbiter;

    localparam int AW = 31;
    localparam int DW = 64;
    localparam int MW = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           srst;
    logic           tb_en    [2];
    logic           tb_write [2];
    logic [AW-1:0]  tb_addr  [2];
    logic [DW-1:0]  tb_wdata [2];
    logic [MW-1:0]  tb_wmask [2];

    logic           m0_rdy, m1_rdy, m0_rd_valid, m1_rd_valid;
    logic [DW-1:0]  m0_rd_data, m1_rd_data;
    logic [AW-1:0]  app_addr;
    logic [2:0]     app_cmd;
    logic           app_en, app_wdf_wren, app_wdf_end, rd_orphan_err;
    logic [DW-1:0]  app_wdf_data;
    logic [MW-1:0]  app_wdf_mask;
    logic           app_rdy, app_wdf_rdy, app_rd_data_valid, init_calib_complete;
    logic [DW-1:0]  app_rd_data;

    xui_arbiter #(.ADDR_SIZE(AW), .DATA_SIZE(DW), .RDQ_DEPTH(8)) dut (
        .ui_clk              (clk),
        .ui_clk_sync_rst     (srst),
        .m0_en               (tb_en[0]),
        .m0_write            (tb_write[0]),
        .m0_addr             (tb_addr[0]),
        .m0_wdata            (tb_wdata[0]),
        .m0_wmask            (tb_wmask[0]),
        .m0_rdy              (m0_rdy),
        .m0_rd_data          (m0_rd_data),
        .m0_rd_valid         (m0_rd_valid),
        .m1_en               (tb_en[1]),
        .m1_write            (tb_write[1]),
        .m1_addr             (tb_addr[1]),
        .m1_wdata            (tb_wdata[1]),
        .m1_wmask            (tb_wmask[1]),
        .m1_rdy              (m1_rdy),
        .m1_rd_data          (m1_rd_data),
        .m1_rd_valid         (m1_rd_valid),
        .app_addr            (app_addr),
        .app_cmd             (app_cmd),
        .app_en              (app_en),
        .app_rdy             (app_rdy),
        .app_wdf_data        (app_wdf_data),
        .app_wdf_mask        (app_wdf_mask),
        .app_wdf_wren        (app_wdf_wren),
        .app_wdf_end         (app_wdf_end),
        .app_wdf_rdy         (app_wdf_rdy),
        .app_rd_data         (app_rd_data),
        .app_rd_data_valid   (app_rd_data_valid),
        .init_calib_complete (init_calib_complete),
        .rd_orphan_err       (rd_orphan_err)
    );

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;
    logic mig_auto = 1'b0;

    // scoreboard queues
    int            exp_grant [$];
    logic [33:0]   exp_cmd   [$];   // {cmd, addr}
    logic [71:0]   exp_wd    [$];   // {data, mask}
    logic [64:0]   exp_rd    [$];   // {requester, data}
    // MIG read-return model
    int            rsp_due   [$];
    logic [DW-1:0] rsp_dat   [$];

    function automatic logic [DW-1:0] rdat(input logic [AW-1:0] a);
        return {32'hDA7A_0000, 1'b0, a};
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        srst = 1'b1;
        for (int i = 0; i < 2; i++) tb_en[i] = 1'b0;
        app_rd_data_valid = 1'b0;
        repeat (2) tick();
        srst = 1'b0;
    endtask

    // issue cnt back-to-back reads from requester n, holding en between them
    task automatic req_seq(input int n, input logic [AW-1:0] a0, input int cnt);
        bit got;
        for (int i = 0; i < cnt; i++) begin
            tb_addr[n]  = a0 + AW'(4 * i);
            tb_write[n] = 1'b0;
            tb_en[n]    = 1'b1;
            got = 1'b0;
            for (int k = 0; k < 100 && !got; k++) begin
                @(negedge clk);
                if ((n == 0) ? m0_rdy : m1_rdy) got = 1'b1;
            end
            if (!got) begin
                n_cmp++;
                n_err++;
                $display("FAIL req_timeout: requester %0d got no rdy, required rdy within 100 cycles", n);
            end
            tick();
        end
        tb_en[n] = 1'b0;
    endtask

    // monitor: every DUT-presented transaction is popped and compared
    initial begin
        logic prev_rdv;
        logic [33:0] ec;
        logic [71:0] ew;
        logic [64:0] er;
        prev_rdv = 1'b0;
        forever begin
            @(negedge clk);
            if (m0_rdy && m1_rdy) chk("dual_rdy", 2'b11, 2'b01);
            if (m0_rdy || m1_rdy) begin
                if (exp_grant.size() == 0) chk("grant_unexpected", {1'b1, m1_rdy}, 2'b00);
                else begin
                    chk("grant_owner", m1_rdy, exp_grant.pop_front());
                    $display("grant requester %0d", m1_rdy);
                end
            end
            if (app_en && app_rdy) begin
                if (app_cmd == 3'b001 && mig_auto) begin
                    rsp_due.push_back(cyc + 5);
                    rsp_dat.push_back(rdat(app_addr));
                end
                if (exp_cmd.size() == 0) chk("cmd_unexpected", {app_cmd, app_addr}, 0);
                else begin
                    ec = exp_cmd.pop_front();
                    chk("cmd", {app_cmd, app_addr}, ec);
                    $display("cmd %0d addr %0h", app_cmd, app_addr);
                end
            end
            if (app_wdf_wren && app_wdf_rdy) begin
                chk("wdf_end", app_wdf_end, 1'b1);
                if (exp_wd.size() == 0) chk("wdata_unexpected", {app_wdf_data, app_wdf_mask}, 0);
                else begin
                    ew = exp_wd.pop_front();
                    chk("wdata", {app_wdf_data, app_wdf_mask}, ew);
                    $display("wdata %0h mask %0h", app_wdf_data, app_wdf_mask);
                end
            end
            if (m0_rd_valid || m1_rd_valid) begin
                chk("rd_latency", prev_rdv, 1'b1);
                chk("rd_valid_onehot", {m1_rd_valid, m0_rd_valid} == 2'b11, 1'b0);
                if (exp_rd.size() == 0) chk("rd_unexpected", {m1_rd_valid, m0_rd_valid}, 2'b00);
                else begin
                    er = exp_rd.pop_front();
                    chk("rd_return", {m1_rd_valid, m1_rd_valid ? m1_rd_data : m0_rd_data}, er);
                    $display("read return requester %0d data %0h", m1_rd_valid, m0_rd_data);
                end
            end
            prev_rdv = app_rd_data_valid;
        end
    end

    // MIG read responder: returns each accepted read five cycles later
    initial begin
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (mig_auto) begin
                if (rsp_due.size() > 0 && rsp_due[0] <= cyc) begin
                    app_rd_data_valid = 1'b1;
                    app_rd_data       = rsp_dat.pop_front();
                    void'(rsp_due.pop_front());
                end else begin
                    app_rd_data_valid = 1'b0;
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached, required $finish earlier");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 2; i++) begin
            tb_en[i] = 1'b0; tb_write[i] = 1'b0; tb_addr[i] = '0;
            tb_wdata[i] = '0; tb_wmask[i] = '0;
        end
        app_rdy = 1'b1; app_wdf_rdy = 1'b1; app_rd_data_valid = 1'b0;
        app_rd_data = '0; init_calib_complete = 1'b1; srst = 1'b1;

        // reset values
        do_reset();
        @(negedge clk);
        chk("rst_app_en", app_en, 1'b0);
        chk("rst_wren", app_wdf_wren, 1'b0);
        chk("rst_wdf_end", app_wdf_end, 1'b0);
        chk("rst_app_cmd", app_cmd, 3'b001);
        chk("rst_app_addr", app_addr, 0);
        chk("rst_wdf_data", {app_wdf_data, app_wdf_mask}, 0);
        chk("rst_orphan", rd_orphan_err, 1'b0);
        chk("rst_rd_valid", {m1_rd_valid, m0_rd_valid}, 2'b00);

        // single write, both MIG channels ready
        do_reset();
        exp_grant.push_back(0);
        exp_cmd.push_back({3'b000, 31'h100});
        exp_wd.push_back({64'hA5A5, 8'h00});
        tb_en[0] = 1'b1; tb_write[0] = 1'b1; tb_addr[0] = 31'h100;
        tb_wdata[0] = 64'hA5A5; tb_wmask[0] = 8'h00;
        @(negedge clk);
        chk("wr_m0_rdy_c0", m0_rdy, 1'b1);
        chk("wr_m1_rdy_c0", m1_rdy, 1'b0);
        tick();
        tb_en[0] = 1'b0;
        @(negedge clk);
        chk("wr_app_en_c1", app_en, 1'b1);
        chk("wr_wren_c1", app_wdf_wren, 1'b1);
        chk("wr_end_c1", app_wdf_end, 1'b1);
        chk("wr_cmd_c1", app_cmd, 3'b000);
        tick();
        @(negedge clk);
        chk("wr_app_en_c2", app_en, 1'b0);
        chk("wr_wren_c2", app_wdf_wren, 1'b0);

        // both requesters streaming reads: alternate grants and steer returns
        do_reset();
        mig_auto = 1'b1;
        exp_grant.push_back(0); exp_grant.push_back(1);
        exp_grant.push_back(0); exp_grant.push_back(1);
        exp_cmd.push_back({3'b001, 31'h200}); exp_cmd.push_back({3'b001, 31'h300});
        exp_cmd.push_back({3'b001, 31'h204}); exp_cmd.push_back({3'b001, 31'h304});
        exp_rd.push_back({1'b0, rdat(31'h200)}); exp_rd.push_back({1'b1, rdat(31'h300)});
        exp_rd.push_back({1'b0, rdat(31'h204)}); exp_rd.push_back({1'b1, rdat(31'h304)});
        fork
            req_seq(0, 31'h200, 2);
            req_seq(1, 31'h300, 2);
        join
        repeat (20) tick();
        mig_auto = 1'b0;
        app_rd_data_valid = 1'b0;
        tick();

        // write data channel stalls three cycles after the command is taken
        do_reset();
        app_wdf_rdy = 1'b0;
        exp_grant.push_back(0); exp_grant.push_back(1);
        exp_cmd.push_back({3'b000, 31'h400}); exp_cmd.push_back({3'b000, 31'h500});
        exp_wd.push_back({64'h1234, 8'h0F}); exp_wd.push_back({64'h5555, 8'h00});
        tb_en[0] = 1'b1; tb_write[0] = 1'b1; tb_addr[0] = 31'h400;
        tb_wdata[0] = 64'h1234; tb_wmask[0] = 8'h0F;
        tb_en[1] = 1'b1; tb_write[1] = 1'b1; tb_addr[1] = 31'h500;
        tb_wdata[1] = 64'h5555; tb_wmask[1] = 8'h00;
        @(negedge clk);
        chk("stall_m0_rdy_c0", m0_rdy, 1'b1);
        for (int c = 1; c <= 4; c++) begin
            tick();
            if (c == 1) tb_en[0] = 1'b0;
            if (c == 4) app_wdf_rdy = 1'b1;
            @(negedge clk);
            chk($sformatf("stall_app_en_c%0d", c), app_en, (c == 1) ? 1'b1 : 1'b0);
            chk($sformatf("stall_wren_c%0d", c), app_wdf_wren, 1'b1);
            chk($sformatf("stall_m1_rdy_c%0d", c), m1_rdy, 1'b0);
        end
        tick();
        @(negedge clk);
        chk("stall_m1_rdy_c5", m1_rdy, 1'b1);
        tick();
        tb_en[1] = 1'b0;
        repeat (2) tick();

        // owner FIFO full: reads blocked, writes still go, one return frees a slot
        do_reset();
        for (int i = 0; i < 8; i++) begin
            exp_grant.push_back(0);
            exp_cmd.push_back({3'b001, 31'h600 + 31'(4 * i)});
        end
        exp_grant.push_back(1); exp_cmd.push_back({3'b000, 31'h800});
        exp_wd.push_back({64'hBEEF, 8'h00});
        exp_grant.push_back(0); exp_cmd.push_back({3'b001, 31'h620});
        exp_rd.push_back({1'b0, rdat(31'h600)});
        req_seq(0, 31'h600, 8);
        tb_en[0] = 1'b1; tb_write[0] = 1'b0; tb_addr[0] = 31'h620;
        tb_en[1] = 1'b1; tb_write[1] = 1'b1; tb_addr[1] = 31'h800;
        tb_wdata[1] = 64'hBEEF; tb_wmask[1] = 8'h00;
        tick();
        @(negedge clk);
        chk("full_m1_rdy", m1_rdy, 1'b1);
        chk("full_m0_rdy", m0_rdy, 1'b0);
        tick();
        tb_en[1] = 1'b0;
        for (int c = 0; c < 4; c++) begin
            tick();
            @(negedge clk);
            chk($sformatf("full_m0_blocked_%0d", c), m0_rdy, 1'b0);
        end
        tick();
        app_rd_data_valid = 1'b1; app_rd_data = rdat(31'h600);
        @(negedge clk);
        chk("full_m0_blocked_pop", m0_rdy, 1'b0);
        tick();
        app_rd_data_valid = 1'b0;
        @(negedge clk);
        chk("full_m0_granted", m0_rdy, 1'b1);
        tick();
        tb_en[0] = 1'b0;
        repeat (2) tick();

        // read data with nothing outstanding
        do_reset();
        app_rd_data_valid = 1'b1; app_rd_data = 64'h99;
        tick();
        app_rd_data_valid = 1'b0;
        @(negedge clk);
        chk("orphan_set", rd_orphan_err, 1'b1);
        repeat (3) tick();
        @(negedge clk);
        chk("orphan_sticky", rd_orphan_err, 1'b1);
        do_reset();
        @(negedge clk);
        chk("orphan_cleared", rd_orphan_err, 1'b0);

        // reset lands while a read is being accepted
        do_reset();
        app_rdy = 1'b0;
        exp_grant.push_back(0);
        exp_cmd.push_back({3'b001, 31'h700});
        tb_en[0] = 1'b1; tb_write[0] = 1'b0; tb_addr[0] = 31'h700;
        tick();
        tb_en[0] = 1'b0; app_rdy = 1'b1; srst = 1'b1;
        @(negedge clk);
        chk("rstmid_app_en_c1", app_en, 1'b1);
        tick();
        @(negedge clk);
        chk("rstmid_app_en_c2", app_en, 1'b0);
        chk("rstmid_wren_c2", app_wdf_wren, 1'b0);
        tick();
        srst = 1'b0;
        @(negedge clk);
        chk("rstmid_orphan_clear", rd_orphan_err, 1'b0);
        tick();
        app_rd_data_valid = 1'b1; app_rd_data = 64'h77;
        tick();
        app_rd_data_valid = 1'b0;
        @(negedge clk);
        chk("rstmid_fifo_flushed", rd_orphan_err, 1'b1);
        repeat (2) tick();

        chk("left_grants", exp_grant.size(), 0);
        chk("left_cmds", exp_cmd.size(), 0);
        chk("left_wdata", exp_wd.size(), 0);
        chk("left_reads", exp_rd.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
